// File: rtl/ondra_pkg.sv
// Shared types and defaults for the Ondra ROM loader: FSM states, slot geometry
// and the ioctl index that maps to the first ROM slot.
package ondra_pkg;

  localparam int ROM_AW_DEFAULT         = 14;
  localparam int SLOTS_DEFAULT          = 3;
  localparam int HOLD_CYCLES_DEFAULT    = 16;
  localparam int ROM_INDEX_BASE_DEFAULT = 1;

  localparam logic [1:0] SLOT_VILI  = 2'd0;
  localparam logic [1:0] SLOT_TESLA = 2'd1;
  localparam logic [1:0] SLOT_TEST  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_e;

  // OSD encodings above the last populated slot fall back to the last slot.
  function automatic logic [1:0] clamp_sel(input logic [1:0] sel, input int slots);
    logic [1:0] last;
    last = 2'(slots - 1);
    return (sel > last) ? last : sel;
  endfunction

endpackage

// File: rtl/ondra_reset_stretch.sv
// Loadable down-counter that keeps the core in reset for a fixed number of
// cycles and flags the final counting cycle with done_o.
module ondra_reset_stretch #(
  parameter int HOLD_CYCLES = 16
) (
  input  logic clk_i,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (load_i) begin
      cnt_q <= CW'(HOLD_CYCLES);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // Done fires on the edge that takes the counter to zero; a reload wins.
  assign done_o = en_i && !load_i && (cnt_q <= CW'(1));

endmodule

// File: rtl/ondra_rom_loader.sv
// Steers HPS ioctl ROM downloads into the multi-slot ROM RAM and owns the Ondra
// core reset, so bank changes only ever happen while the core is held in reset.
module ondra_rom_loader
  import ondra_pkg::*;
#(
  parameter int ROM_AW         = ROM_AW_DEFAULT,
  parameter int SLOTS          = SLOTS_DEFAULT,
  parameter int HOLD_CYCLES    = HOLD_CYCLES_DEFAULT,
  parameter int ROM_INDEX_BASE = ROM_INDEX_BASE_DEFAULT
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_data,
  input  logic [7:0]        ioctl_index,
  input  logic [1:0]        rom_sel,
  input  logic              user_reset,
  output logic              rom_we,
  output logic [ROM_AW+1:0] rom_waddr,
  output logic [7:0]        rom_wdata,
  output logic [1:0]        rom_bank,
  output logic              core_reset,
  output logic [SLOTS-1:0]  slot_valid,
  output logic              overflow,
  output logic              busy_led
);

  state_e             state_q, state_d;
  logic [1:0]         slot_q, slot_d;
  logic [1:0]         rom_bank_q, rom_bank_d;
  logic [1:0]         sel_clamped, idx_slot;
  logic [7:0]         idx_off;
  logic               idx_hit, start_load, addr_ok, wr_accept;
  logic               hold_load, hold_done, written_q;
  logic               rom_we_q, core_reset_q, overflow_q;
  logic [ROM_AW+1:0]  rom_waddr_q;
  logic [7:0]         rom_wdata_q;
  logic [SLOTS-1:0]   slot_valid_q, clr_mask, set_mask;

  assign idx_off     = ioctl_index - 8'(ROM_INDEX_BASE);
  assign idx_hit     = (ioctl_index >= 8'(ROM_INDEX_BASE)) && (idx_off < 8'(SLOTS));
  assign idx_slot    = idx_off[1:0];
  assign start_load  = ioctl_download && idx_hit;
  assign addr_ok     = (ioctl_addr[24:ROM_AW] == '0);
  assign wr_accept   = (state_q == LOAD) && ioctl_wr && addr_ok;
  assign sel_clamped = clamp_sel(rom_sel, SLOTS);
  assign clr_mask    = SLOTS'(1) << slot_d;
  assign set_mask    = SLOTS'(1) << slot_q;

  ondra_reset_stretch #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_stretch (
    .clk_i (clk_sys),
    .load_i(reset || hold_load),
    .en_i  (state_q == HOLD),
    .done_o(hold_done)
  );

  // A new download always wins; otherwise HOLD waits for the stretch counter.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    rom_bank_d = rom_bank_q;
    hold_load  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_load) begin
          state_d = LOAD;
          slot_d  = idx_slot;
        end else if (user_reset || (sel_clamped != rom_bank_q)) begin
          state_d   = HOLD;
          hold_load = 1'b1;
        end
      end
      LOAD: begin
        if (!ioctl_download) begin
          state_d   = HOLD;
          hold_load = 1'b1;
        end
      end
      HOLD: begin
        if (start_load) begin
          state_d = LOAD;
          slot_d  = idx_slot;
        end else if (user_reset) begin
          hold_load = 1'b1;
        end else if (hold_done) begin
          state_d    = IDLE;
          rom_bank_d = sel_clamped;
        end
      end
      default: begin
        state_d   = HOLD;
        hold_load = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= HOLD;
      slot_q       <= SLOT_VILI;
      rom_bank_q   <= SLOT_VILI;
      rom_we_q     <= 1'b0;
      rom_waddr_q  <= '0;
      rom_wdata_q  <= '0;
      core_reset_q <= 1'b1;
      slot_valid_q <= '0;
      overflow_q   <= 1'b0;
      written_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      rom_bank_q   <= rom_bank_d;
      // Released only once IDLE is stable, one cycle after the bank update.
      core_reset_q <= !((state_q == IDLE) && (state_d == IDLE));
      rom_we_q     <= wr_accept;
      if (wr_accept) begin
        rom_waddr_q <= {slot_q, ioctl_addr[ROM_AW-1:0]};
        rom_wdata_q <= ioctl_data;
      end
      if ((state_q == LOAD) && ioctl_wr && !addr_ok) begin
        overflow_q <= 1'b1;
      end
      if ((state_q != LOAD) && (state_d == LOAD)) begin
        slot_valid_q <= slot_valid_q & ~clr_mask;
        written_q    <= 1'b0;
      end else if ((state_q == LOAD) && (state_d == HOLD)) begin
        if (written_q || wr_accept) begin
          slot_valid_q <= slot_valid_q | set_mask;
        end
      end else if (wr_accept) begin
        written_q <= 1'b1;
      end
    end
  end

  assign rom_we     = rom_we_q;
  assign rom_waddr  = rom_waddr_q;
  assign rom_wdata  = rom_wdata_q;
  assign rom_bank   = rom_bank_q;
  assign core_reset = core_reset_q;
  assign slot_valid = slot_valid_q;
  assign overflow   = overflow_q;
  assign busy_led   = (state_q == LOAD);

endmodule

// File: tb/tb_ondra_rom_loader.sv
// Self-checking bench for ondra_rom_loader: directed scenarios plus randomized
// downloads compared against a slot/byte-level reference model.
module tb_ondra_rom_loader;

  localparam int PULSE    = 17;
  localparam int ROM_SIZE = 16384;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic [7:0]  ioctl_index = '0;
  logic [1:0]  rom_sel = '0;
  logic        user_reset = 1'b0;
  logic        rom_we;
  logic [15:0] rom_waddr;
  logic [7:0]  rom_wdata;
  logic [1:0]  rom_bank;
  logic        core_reset;
  logic [2:0]  slot_valid;
  logic        overflow;
  logic        busy_led;

  int errors = 0;
  int checks = 0;
  logic [23:0] captured[$];
  logic [23:0] expQ[$];

  ondra_rom_loader dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
    .ioctl_index(ioctl_index), .rom_sel(rom_sel), .user_reset(user_reset),
    .rom_we(rom_we), .rom_waddr(rom_waddr), .rom_wdata(rom_wdata),
    .rom_bank(rom_bank), .core_reset(core_reset), .slot_valid(slot_valid),
    .overflow(overflow), .busy_led(busy_led)
  );

  always #5 clk_sys = ~clk_sys;

  // Every ROM write the DUT performs, in order, as {address, data}.
  always @(negedge clk_sys) begin
    if (rom_we === 1'b1) captured.push_back({rom_waddr, rom_wdata});
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Counts the remaining core_reset-high cycles, bounded; banks at both ends.
  task automatic wait_release(output int n, output logic [1:0] firstBank, output logic [1:0] lastBank);
    n = 0;
    firstBank = rom_bank;
    lastBank = rom_bank;
    while (core_reset === 1'b1 && n < 200) begin
      lastBank = rom_bank;
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    int n;
    logic [1:0] b0, b1;
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (core_reset !== 1'b1) begin errors++; $display("[TB] FAIL reset_core_reset: got %b expected 1", core_reset); end
    checks++; if ({rom_we, rom_waddr, rom_wdata} !== 25'd0) begin errors++; $display("[TB] FAIL reset_write_port: got %b/%h/%h expected 0/0/0", rom_we, rom_waddr, rom_wdata); end
    checks++; if ({rom_bank, slot_valid, overflow, busy_led} !== 7'd0) begin errors++; $display("[TB] FAIL reset_status: got bank=%0d valid=%b ovf=%b busy=%b expected all 0", rom_bank, slot_valid, overflow, busy_led); end
    reset = 1'b0;
    wait_release(n, b0, b1);
    checks++; if (n !== PULSE) begin errors++; $display("[TB] FAIL powerup_pulse: got %0d cycles expected %0d", n, PULSE); end
    checks++; if (b1 !== 2'd0) begin errors++; $display("[TB] FAIL powerup_bank: got %0d expected 0", b1); end
  endtask

  task automatic test_load_basic();
    int n;
    logic [1:0] b0, b1;
    ioctl_index = 8'd2;
    ioctl_download = 1'b1;
    tick();
    checks++; if ({busy_led, core_reset} !== 2'b11) begin errors++; $display("[TB] FAIL load_entry: got busy=%b core_reset=%b expected 1/1", busy_led, core_reset); end
    for (int i = 0; i < 4; i++) begin
      ioctl_wr = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_data = 8'(8'hA0 + i);
      tick();
      checks++;
      if (rom_we !== 1'b1 || rom_waddr !== 16'(32'h4000 + i) || rom_wdata !== 8'(8'hA0 + i)) begin
        errors++;
        $display("[TB] FAIL load_byte%0d: got we=%b addr=%h data=%h expected 1/%h/%h", i, rom_we, rom_waddr, rom_wdata, 16'(32'h4000 + i), 8'(8'hA0 + i));
      end
    end
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    tick();
    checks++; if (rom_we !== 1'b0) begin errors++; $display("[TB] FAIL load_we_off: got %b expected 0", rom_we); end
    checks++; if (slot_valid !== 3'b010) begin errors++; $display("[TB] FAIL load_valid: got %b expected 010", slot_valid); end
    wait_release(n, b0, b1);
    checks++; if (n !== PULSE) begin errors++; $display("[TB] FAIL load_hold: got %0d cycles expected %0d", n, PULSE); end
    captured.delete();
  endtask

  task automatic test_overflow();
    int n;
    logic [1:0] b0, b1;
    captured.delete();
    ioctl_index = 8'd1;
    ioctl_download = 1'b1;
    tick();
    ioctl_wr = 1'b1; ioctl_addr = 25'd5; ioctl_data = 8'($urandom);
    tick();
    ioctl_addr = 25'h4000;
    tick();
    checks++; if (rom_we !== 1'b0) begin errors++; $display("[TB] FAIL ovf_no_write: got %b expected 0", rom_we); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag: got %b expected 1", overflow); end
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    tick();
    wait_release(n, b0, b1);
    checks++; if (captured.size() !== 1) begin errors++; $display("[TB] FAIL ovf_write_count: got %0d expected 1", captured.size()); end
    checks++; if ({slot_valid, overflow} !== 4'b0111) begin errors++; $display("[TB] FAIL ovf_sticky: got valid=%b ovf=%b expected 011/1", slot_valid, overflow); end
    reset = 1'b1;
    tick();
    checks++; if ({slot_valid, overflow} !== 4'b0000) begin errors++; $display("[TB] FAIL ovf_cleared: got valid=%b ovf=%b expected 000/0", slot_valid, overflow); end
    reset = 1'b0;
    wait_release(n, b0, b1);
    captured.delete();
  endtask

  task automatic test_user_reset();
    int n;
    logic [1:0] b0, b1;
    user_reset = 1'b1;
    tick();
    user_reset = 1'b0;
    wait_release(n, b0, b1);
    checks++; if (n !== PULSE) begin errors++; $display("[TB] FAIL user_reset_pulse: got %0d expected %0d", n, PULSE); end
    user_reset = 1'b1;
    tick();
    user_reset = 1'b0;
    repeat (5) tick();
    user_reset = 1'b1;
    tick();
    user_reset = 1'b0;
    wait_release(n, b0, b1);
    checks++; if (6 + n !== 6 + PULSE) begin errors++; $display("[TB] FAIL user_reset_reload: got %0d cycles expected %0d", 6 + n, 6 + PULSE); end
  endtask

  task automatic test_rom_sel();
    int n;
    logic [1:0] b0, b1;
    rom_sel = 2'd1;
    tick();
    wait_release(n, b0, b1);
    checks++; if (n !== PULSE) begin errors++; $display("[TB] FAIL sel_pulse: got %0d expected %0d", n, PULSE); end
    checks++; if ({b0, b1} !== {2'd0, 2'd1}) begin errors++; $display("[TB] FAIL sel_bank: got first=%0d last=%0d expected 0/1", b0, b1); end
    checks++; if (rom_bank !== 2'd1 || core_reset !== 1'b0) begin errors++; $display("[TB] FAIL sel_after: got bank=%0d core_reset=%b expected 1/0", rom_bank, core_reset); end
  endtask

  task automatic test_sel_during_load();
    int n;
    logic [1:0] b0, b1;
    int bankErr = 0;
    rom_sel = 2'd0;
    tick();
    wait_release(n, b0, b1);
    ioctl_index = 8'd3;
    ioctl_download = 1'b1;
    tick();
    rom_sel = 2'd2;
    for (int i = 0; i < 2; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_data = 8'($urandom);
      tick();
      if (rom_bank !== 2'd0) bankErr++;
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    tick();
    if (rom_bank !== 2'd0) bankErr++;
    checks++; if (bankErr !== 0) begin errors++; $display("[TB] FAIL defer_bank: got %0d early bank changes expected 0", bankErr); end
    wait_release(n, b0, b1);
    checks++; if (b1 !== 2'd2 || n !== PULSE) begin errors++; $display("[TB] FAIL defer_switch: got bank=%0d pulse=%0d expected 2/%0d", b1, n, PULSE); end
    rom_sel = 2'd0;
    tick();
    wait_release(n, b0, b1);
    rom_sel = 2'd3;
    tick();
    wait_release(n, b0, b1);
    repeat (4) tick();
    checks++; if (rom_bank !== 2'd2 || core_reset !== 1'b0) begin errors++; $display("[TB] FAIL clamp_sel3: got bank=%0d core_reset=%b expected 2/0", rom_bank, core_reset); end
    rom_sel = 2'd0;
    tick();
    wait_release(n, b0, b1);
    captured.delete();
  endtask

  task automatic test_random();
    int n, cnt, written;
    logic [1:0] b0, b1, slot;
    logic [7:0] idxTable[6];
    logic [7:0] idx;
    logic [24:0] addr;
    logic [7:0] data;
    logic [2:0] expValid;
    logic expOvf;
    bit isRom, coincide;
    idxTable = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd7};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_release(n, b0, b1);
    expValid = '0;
    expOvf = 1'b0;
    for (int it = 0; it < 10; it++) begin
      idx = idxTable[$urandom_range(0, 5)];
      isRom = (idx >= 8'd1 && idx <= 8'd3);
      slot = 2'(idx - 8'd1);
      cnt = $urandom_range(1, 6);
      written = 0;
      captured.delete();
      expQ.delete();
      ioctl_index = idx;
      ioctl_download = 1'b1;
      tick();
      for (int k = 0; k < cnt; k++) begin
        if ($urandom_range(0, 1) == 1) begin ioctl_wr = 1'b0; tick(); end
        addr = ($urandom_range(0, 7) == 0) ? 25'(32'h4000 + $urandom_range(0, 255)) : 25'($urandom_range(0, ROM_SIZE - 1));
        data = 8'($urandom);
        coincide = (k == cnt - 1) && ($urandom_range(0, 1) == 1);
        ioctl_wr = 1'b1; ioctl_addr = addr; ioctl_data = data;
        if (coincide) ioctl_download = 1'b0;
        if (isRom) begin
          if (addr < 25'(ROM_SIZE)) begin
            expQ.push_back({slot, addr[13:0], data});
            written++;
          end else begin
            expOvf = 1'b1;
          end
        end
        tick();
      end
      ioctl_wr = 1'b0;
      if (ioctl_download) begin ioctl_download = 1'b0; tick(); end
      if (isRom) begin
        expValid[slot] = (written > 0);
        wait_release(n, b0, b1);
        checks++; if (n !== PULSE) begin errors++; $display("[TB] FAIL rand%0d_pulse: got %0d expected %0d", it, n, PULSE); end
      end else begin
        tick();
        checks++; if (core_reset !== 1'b0) begin errors++; $display("[TB] FAIL rand%0d_ignored: got core_reset=%b expected 0", it, core_reset); end
      end
      checks++; if ({slot_valid, overflow} !== {expValid, expOvf}) begin errors++; $display("[TB] FAIL rand%0d_status: got valid=%b ovf=%b expected %b/%b", it, slot_valid, overflow, expValid, expOvf); end
      checks++; if (captured.size() !== expQ.size()) begin errors++; $display("[TB] FAIL rand%0d_count: got %0d writes expected %0d", it, captured.size(), expQ.size()); end
      for (int i = 0; i < captured.size() && i < expQ.size(); i++) begin
        checks++; if (captured[i] !== expQ[i]) begin errors++; $display("[TB] FAIL rand%0d_write%0d: got %h expected %h", it, i, captured[i], expQ[i]); end
      end
    end
    captured.delete();
  endtask

  task automatic test_reset_mid_load();
    int n;
    logic [1:0] b0, b1;
    ioctl_index = 8'd2;
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_data = 8'($urandom);
      tick();
    end
    ioctl_addr = 25'd2;
    reset = 1'b1;
    tick();
    checks++; if (rom_we !== 1'b0) begin errors++; $display("[TB] FAIL abort_we: got %b expected 0", rom_we); end
    checks++; if (slot_valid[1] !== 1'b0 || busy_led !== 1'b0 || core_reset !== 1'b1) begin errors++; $display("[TB] FAIL abort_state: got valid=%b busy=%b core_reset=%b expected 0/0/1", slot_valid[1], busy_led, core_reset); end
    reset = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    wait_release(n, b0, b1);
    checks++; if (n !== PULSE) begin errors++; $display("[TB] FAIL abort_hold: got %0d expected %0d", n, PULSE); end
    captured.delete();
  endtask

  task automatic test_bad_index();
    int weCount = 0;
    ioctl_index = 8'd7;
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_data = 8'($urandom);
      tick();
      if (rom_we !== 1'b0) weCount++;
    end
    checks++; if (weCount !== 0) begin errors++; $display("[TB] FAIL bad_index_we: got %0d writes expected 0", weCount); end
    checks++; if (core_reset !== 1'b0 || busy_led !== 1'b0) begin errors++; $display("[TB] FAIL bad_index_state: got core_reset=%b busy=%b expected 0/0", core_reset, busy_led); end
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_overflow();
    test_user_reset();
    test_rom_sel();
    test_sel_during_load();
    test_random();
    test_reset_mid_load();
    test_bad_index();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
